// File: rtl/wb_arbiter_if.sv
// Write-back request/grant bundle between the execution channels and the
// register-file arbiter.
interface wb_arbiter_if;
  logic [3:0] req;
  logic [4:0] rd0;
  logic [4:0] rd1;
  logic [4:0] rd2;
  logic [4:0] rd3;
  logic       flush;
  logic [3:0] ack;
  logic [2:0] reg_src_sel;
  logic       reg_write;
  logic [4:0] reg_waddr;
  logic       busy;

  modport master (
    output req, rd0, rd1, rd2, rd3, flush,
    input  ack, reg_src_sel, reg_write, reg_waddr, busy
  );

  modport slave (
    input  req, rd0, rd1, rd2, rd3, flush,
    output ack, reg_src_sel, reg_write, reg_waddr, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Four-channel round-robin write-back arbiter: one register-file write per
// cycle, back-to-back grants while other channels keep requesting.
module wb_arbiter #(
  parameter logic [2:0] SRC_0 = 3'd1,
  parameter logic [2:0] SRC_1 = 3'd2,
  parameter logic [2:0] SRC_2 = 3'd3,
  parameter logic [2:0] SRC_3 = 3'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  wb_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] r_state;
  logic [1:0] r_rr_ptr;
  logic [1:0] r_win;
  logic [4:0] r_rd;

  logic       w_in_grant;
  logic [1:0] w_base;
  logic [3:0] w_mask;
  logic [3:0] w_cand;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_win;
  logic       w_arb;
  logic [4:0] w_rd_sel;
  logic [2:0] w_src;

  assign w_in_grant = (r_state == ST_GRANT);

  // From GRANT the search starts just past the channel being acked, which is
  // where rr_ptr lands once this write retires; that channel is masked out.
  assign w_base = w_in_grant ? (r_win + 2'd1) : r_rr_ptr;
  assign w_mask = w_in_grant ? (4'b0001 << r_win) : 4'b0000;
  assign w_cand = bus.req & ~w_mask;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign w_rot[gi] = w_cand[w_base + 2'(gi)];
    end
  endgenerate

  always_comb begin
    w_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_rot[k]) w_off = 2'(k);
    end
  end

  assign w_win = w_base + w_off;
  assign w_arb = (|w_cand) && !bus.flush;

  always_comb begin
    w_rd_sel = bus.rd0;
    case (w_win)
      2'd0:    w_rd_sel = bus.rd0;
      2'd1:    w_rd_sel = bus.rd1;
      2'd2:    w_rd_sel = bus.rd2;
      default: w_rd_sel = bus.rd3;
    endcase
  end

  always_comb begin
    w_src = SRC_0;
    case (r_win)
      2'd0:    w_src = SRC_0;
      2'd1:    w_src = SRC_1;
      2'd2:    w_src = SRC_2;
      default: w_src = SRC_3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 2'd0;
      r_win    <= 2'd0;
      r_rd     <= 5'd0;
    end else begin
      // A flushed grant never retires, so the pointer stays put.
      if (w_in_grant && !bus.flush) begin
        r_rr_ptr <= r_win + 2'd1;
      end
      if (w_arb) begin
        r_state <= ST_GRANT;
        r_win   <= w_win;
        r_rd    <= w_rd_sel;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign bus.ack         = (w_in_grant && !bus.flush) ? (4'b0001 << r_win) : 4'b0000;
  assign bus.reg_write   = w_in_grant && !bus.flush && (r_rd != 5'd0);
  assign bus.reg_src_sel = w_in_grant ? w_src : 3'd0;
  assign bus.reg_waddr   = w_in_grant ? r_rd : 5'd0;
  assign bus.busy        = reset_n && (w_in_grant || (|bus.req));

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter SRC_0, default 3'd1: reg_src_sel code driven when channel 0 wins.
REQ-002 Parameter SRC_1, default 3'd2: reg_src_sel code driven when channel 1 wins.
REQ-003 Parameter SRC_2, default 3'd3: reg_src_sel code driven when channel 2 wins.
REQ-004 Parameter SRC_3, default 3'd4: reg_src_sel code driven when channel 3 wins.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk, input, 1: rising-edge clock.
REQ-007 reset_n, input, 1: asynchronous active-low reset.
REQ-008 req, input, 4: per-channel write-back request; held high until acked.
REQ-009 rd0, rd1, rd2, rd3, inputs, 5 each: destination register per channel; stable while req is high.
REQ-010 flush, input, 1: abort the pending write and ignore requests this cycle.
REQ-011 ack, output, 4: one-hot; pulses for one cycle to the channel being written.
REQ-012 reg_src_sel, output, 3: select for the register-source mux; code 0 is the idle/constant source.
REQ-013 reg_write, output, 1: register-file write enable.
REQ-014 reg_waddr, output, 5: register-file write address.
REQ-015 busy, output, 1: high in GRANT state or while any req bit is high.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-017 In IDLE with any req bit high and flush low, the block SHALL pick a winner round-robin, register its index and rd, and enter GRANT on the next edge.
REQ-018 Round-robin SHALL search from rr_ptr upward modulo 4; after a grant, rr_ptr SHALL become winner+1 mod 4.
REQ-019 In GRANT, the block SHALL drive reg_src_sel = SRC_<winner>, reg_waddr = registered rd, and ack[winner] = 1, all for exactly one cycle.
REQ-020 reg_write in GRANT SHALL be 1 unless the registered rd is 0; rd = 0 SHALL give reg_write = 0 with ack still asserted.
REQ-021 From GRANT, if any req bit other than the one just acked is high and flush is low, the block SHALL arbitrate in the same cycle and stay in GRANT (back-to-back writes); otherwise it SHALL go to IDLE.
REQ-022 In arbitration from GRANT, the acked channel's req bit SHALL be masked for that cycle.
REQ-023 In IDLE, outputs SHALL be reg_src_sel = 0, reg_write = 0, reg_waddr = 0, ack = 0.
REQ-024 Latency SHALL be one cycle from req high in IDLE to ack; sustained throughput SHALL be one write per cycle under continuous multi-channel requests.
REQ-025 When flush is high in GRANT, reg_write and ack SHALL be 0 that cycle, the next state SHALL be IDLE, and rr_ptr SHALL be unchanged.
REQ-026 When flush is high in IDLE, no grant SHALL be issued.
REQ-027 A channel that is not acked SHALL keep its request pending; the block SHALL not drop unacked requests except through flush (REQ-025).
REQ-028 Outputs SHALL be registered-state decodes with no combinational path from req to reg_write.

Reset
REQ-029 While reset_n = 0, the block SHALL be asynchronously in IDLE with rr_ptr = 0, reg_src_sel = 0, reg_write = 0, reg_waddr = 0, ack = 0, busy = 0.
REQ-030 A reset assertion during GRANT SHALL cancel the write immediately, with no write strobe.

Verification
REQ-031 Single request: req = 0001, rd0 = 5 -> the next cycle gives ack = 0001, reg_src_sel = 1, reg_waddr = 5, reg_write = 1; the cycle after returns to IDLE.
REQ-032 All four requests held from reset -> acks 0001, 0010, 0100, 1000 on consecutive cycles, with reg_src_sel 1, 2, 3, 4.
REQ-033 Channel 2 request with rd2 = 0 -> ack = 0100, reg_write = 0, reg_src_sel = 3.
REQ-034 Flush in the GRANT cycle of channel 1 -> reg_write = 0, ack = 0, next state IDLE; channel 1 is still granted on its next request.
REQ-035 reset_n pulled low mid-GRANT -> reg_write falls immediately; after release, rr_ptr = 0 and channel 0 wins a 1111 request.
REQ-036 Fairness: req = 0011 held with rr_ptr = 1 -> channel 1 is acked before channel 0.
